// File: rtl/photon_bin_hist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : photon_bin_hist_pkg
// Description : Shared types and constants for the photon bin histogrammer.
//               Holds the acquisition state enum, the default NBINS, CNT_W
//               and WIN_W values, and the width of the drain bin index.
// Revision    : 1.0 - initial release
// ============================================================================
package photon_bin_hist_pkg;

    localparam int c_DEF_NBINS = 8;
    localparam int c_DEF_CNT_W = 16;
    localparam int c_DEF_WIN_W = 24;

    // Width of the drain bin index and of the out_bin port
    localparam int c_BIN_IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_INTEGRATE = 2'd1,
        S_DRAIN     = 2'd2
    } hist_state_t;

endpackage
`default_nettype wire

// File: rtl/bin_hit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bin_hit_counter
// Description : One per-bin hit counter for the photon histogrammer.
//               Synchronous clear, increment on inc, ovf flags an increment
//               attempted while the counter sits at its maximum value.
//               Macro PHOTON_BIN_HIST_SAT_EN: defined -> saturate at max,
//               undefined -> wrap modulo 2^CNT_W.
// Ports       : clkin  - clock
//               rstn   - asynchronous active-low reset
//               clear  - zero the counter
//               inc    - add one this cycle
//               count  - current counter value
//               ovf    - increment at max this cycle (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module bin_hit_counter
    import photon_bin_hist_pkg::*;
#(
    parameter int CNT_W = c_DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;
    assign ovf      = inc & w_at_max;
    assign count    = r_count;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
`ifdef PHOTON_BIN_HIST_SAT_EN
            if (!w_at_max) begin
                r_count <= r_count + 1'b1;
            end
`else
            r_count <= r_count + 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/photon_bin_histogrammer.sv
`default_nettype none
// ============================================================================
// Module      : photon_bin_histogrammer
// Description : Accumulates per-bin photon hits over a programmable window,
//               then drains the NBINS totals one word per valid/ready
//               handshake. Optional macro PHOTON_BIN_HIST_SAT_EN makes the
//               bin counters saturate instead of wrap.
// Ports       : clkin     - clock, all logic on the rising edge
//               rstn      - asynchronous active-low reset
//               data      - per-cycle bin hit vector
//               start     - begin an acquisition (accepted in IDLE only)
//               window    - integration length, latched on accepted start
//               busy      - acquisition in progress (INTEGRATE or DRAIN)
//               out_valid - drain word valid
//               out_ready - consumer accepts the drain word
//               out_bin   - bin index of the current word
//               out_count - count of out_bin
//               out_last  - word for the final bin
//               overflow  - sticky counter overflow for this acquisition
// Revision    : 1.0 - initial release
// ============================================================================
module photon_bin_histogrammer
    import photon_bin_hist_pkg::*;
#(
    parameter int NBINS = c_DEF_NBINS,
    parameter int CNT_W = c_DEF_CNT_W,
    parameter int WIN_W = c_DEF_WIN_W
) (
    input  logic                   clkin,
    input  logic                   rstn,
    input  logic [NBINS-1:0]       data,
    input  logic                   start,
    input  logic [WIN_W-1:0]       window,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [c_BIN_IDX_W-1:0] out_bin,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_last,
    output logic                   overflow
);

    localparam logic [c_BIN_IDX_W-1:0] c_LAST_IDX = c_BIN_IDX_W'(NBINS - 1);

    hist_state_t             r_state;
    hist_state_t             w_state_nxt;
    logic [WIN_W-1:0]        r_win;
    logic [c_BIN_IDX_W-1:0]  r_idx;
    logic                    r_overflow;
    logic                    w_accept;
    logic                    w_hand;
    logic [NBINS-1:0]        w_inc;
    logic [NBINS-1:0]        w_ovf;
    logic [CNT_W-1:0]        w_count [NBINS];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. busy/out_valid depend only on
    // the state register, so out_ready never reaches out_valid.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hand      = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_INTEGRATE;
                end
            end
            S_INTEGRATE: begin
                busy = 1'b1;
                // r_win == 1 marks the last sampled cycle
                if (r_win <= WIN_W'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_hand = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Window counter, drain index and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_win      <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                // A zero window still samples one cycle
                r_win <= (window == '0) ? WIN_W'(1) : window;
            end else if (r_state == S_INTEGRATE) begin
                r_win <= r_win - WIN_W'(1);
            end

            if (w_accept) begin
                r_idx <= '0;
            end else if (w_hand) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end

            if (w_accept) begin
                r_overflow <= 1'b0;
            end else if (|w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-bin counters
    // ------------------------------------------------------------------
    assign w_inc = (r_state == S_INTEGRATE) ? data : '0;

    for (genvar gi = 0; gi < NBINS; gi++) begin : g_bins
        bin_hit_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clkin (clkin),
            .rstn  (rstn),
            .clear (w_accept),
            .inc   (w_inc[gi]),
            .count (w_count[gi]),
            .ovf   (w_ovf[gi])
        );
    end

    // ------------------------------------------------------------------
    // Drain outputs: driven from registers only, zero outside DRAIN
    // ------------------------------------------------------------------
    assign out_bin   = r_idx;
    assign out_count = out_valid ? w_count[r_idx] : '0;
    assign out_last  = out_valid && (r_idx == c_LAST_IDX);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/photon_bin_histogrammer.md
# photon_bin_histogrammer

Downstream consumer of the per-cycle 8-bin photon arrival vector produced by the registered clock-to-bins stage. Over a programmable integration window, it accumulates one hit counter per bin. It then drains the eight totals one per handshake to the readout/USB side. This block turns per-cycle sub-period hit flags into a fine-timing histogram per acquisition.

## Interface
Parameters:
- NBINS, 8, number of timing bins; equals the width of `data`.
- CNT_W, 16, width of each bin counter.
- WIN_W, 24, width of the integration-window length.

Ports:
- clkin, in, 1, single clock; all logic on its rising edge.
- rstn, in, 1, reset; asynchronous assert, active-low.
- data, in, NBINS, bin hit vector from the upstream stage; sampled every cycle.
- start, in, 1, single-cycle request to begin an acquisition.
- window, in, WIN_W, integration length in clkin cycles; latched on accepted `start`.
- busy, out, 1, high in INTEGRATE and DRAIN.
- out_valid, out, 1, drain word valid.
- out_ready, in, 1, consumer accepts the drain word.
- out_bin, out, 3, bin index of the current word.
- out_count, out, CNT_W, count for `out_bin`.
- out_last, out, 1, high with the word for bin NBINS-1.
- overflow, out, 1, sticky; set if any counter exceeded its max this acquisition.

## Operation
- States: IDLE, INTEGRATE, DRAIN.
- **IDLE**
  - Counters hold their last values; `busy` = 0 and `out_valid` = 0.
  - `start` = 1: latch `window`, treating 0 as 1. Clear all counters and `overflow`, load the window counter, then go to INTEGRATE.
- **INTEGRATE**
  - Each cycle, for every i with `data[i]` = 1, `count[i]` += 1. Multiple bins may increment in the same cycle.
  - The window counter decrements once per cycle. The cycle it reaches 1 is the last sampled cycle; the next state is DRAIN.
- **DRAIN**
  - `data` is ignored. `out_valid` = 1 and `out_bin` = drain index, starting at 0. `out_count` = `count[out_bin]`.
  - The index advances only when `out_valid` && `out_ready`.
  - The handshake with `out_last` = 1 returns the block to IDLE.
  - `out_bin`, `out_count` and `out_last` are held stable while `out_valid` && !`out_ready`.
- `start` in INTEGRATE or DRAIN is ignored; acquisitions are never restarted or queued.
- Counter overflow: an increment at max count sets `overflow`. The counter value then follows the Configuration section.
- `rstn` low at any time, including mid-INTEGRATE or mid-DRAIN:
  - State becomes IDLE immediately.
  - Counters, window counter, drain index, `overflow`, `out_valid` and `busy` are all cleared. No partial drain is emitted.

## Timing
- Reset values: `busy`, `out_valid`, `out_bin`, `out_count`, `out_last` and `overflow` all 0.
- Accepted `start` at cycle T (window = W): `busy` = 1 from T+1. `data` is sampled at T+1 through T+W inclusive.
- First `out_valid` at T+W+1.
- With `out_ready` held high, bins 0..7 appear on T+W+1..T+W+8. IDLE from T+W+9, and `start` is accepted again at T+W+9.
- `out_count` is registered; there are no combinational paths from `out_ready` to `out_valid`.
- `overflow` becomes 1 in the cycle after the offending increment and stays set until the next accepted `start` or reset.

## Configuration
- Macro: `PHOTON_BIN_HIST_SAT_EN`.
- Defined: counters saturate at 2^CNT_W−1 and `overflow` is set.
- Undefined: counters wrap modulo 2^CNT_W and `overflow` is still set.

## Structure
- Package `photon_bin_hist_pkg`:
  - State enum (IDLE, INTEGRATE, DRAIN).
  - Default NBINS, CNT_W and WIN_W constants.
  - Bin-index width localparam.
- Sub-module `bin_hit_counter`:
  - One CNT_W counter with `clear`, `inc` and `ovf` outputs.
  - Contains the saturate/wrap `ifdef`.
  - Instantiated NBINS times in a generate loop.

## Test plan
- Reset, then `start` with window = 4 and `data` = 8'h81 every cycle; `out_ready` = 1 → counts {4,0,0,0,0,0,0,4}, words on 8 consecutive cycles, `out_last` on bin 7, `overflow` = 0.
- window = 0 with `data` = 8'hFF → treated as 1; every bin count = 1.
- Drain with `out_ready` toggling 1,0,0,1… → no word lost or duplicated, and the outputs stay stable while stalled. `start` pulsed during DRAIN is ignored.
- CNT_W = 4, window = 20, `data[3]` = 1 every cycle → `overflow` = 1. `count[3]` = 15 with the macro, or 4 without it.
- `rstn` pulsed low mid-INTEGRATE → `busy` and `out_valid` drop at once with no drain. A new acquisition afterwards reports only its own hits.
- Back-to-back acquisitions: `start` at the first IDLE cycle → accepted, counters start from 0, and the previous `overflow` is cleared.
